// File: rtl/bsg_cgol_board.sv
// ============================================================================
// Module   : bsg_cgol_board
// Brief    : Conway's Game of Life board. Rows are loaded over valid/ready,
//            the board runs up to the requested number of generations
//            (stopping early once still), and rows are read out over
//            valid/yumi. Define BSG_CGOL_BOARD_TORUS_EN for wrap-around edges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_cgol_board #(
    parameter int width_p     = 8,
    parameter int height_p    = 8,
    parameter int gen_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   data_v_i,
    input  logic [width_p-1:0]     data_i,
    input  logic [gen_width_p-1:0] frames_i,
    output logic                   ready_o,
    output logic                   data_v_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   yumi_i,
    output logic [gen_width_p-1:0] gen_count_o,
    output logic                   stable_o
);

    localparam int                 c_ptr_w    = $clog2(height_p);
    localparam logic [c_ptr_w-1:0] c_last_row = c_ptr_w'(height_p - 1);

`ifdef BSG_CGOL_BOARD_TORUS_EN
    localparam bit c_wrap = 1'b1;
`else
    localparam bit c_wrap = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                               r_state, w_state_next;
    logic [height_p-1:0][width_p-1:0]     r_board, w_board_next;
    logic [c_ptr_w-1:0]                   r_wr_ptr, r_rd_ptr;
    logic [gen_width_p-1:0]               r_frames, r_gen_count, w_gen_inc;
    logic                                 r_stable;
    logic                                 w_in_fire, w_out_fire, w_still, w_frames_hit;

    assign ready_o     = (r_state == IDLE) || (r_state == LOAD);
    assign data_v_o    = (r_state == DONE);
    assign data_o      = data_v_o ? r_board[r_rd_ptr] : '0;
    assign gen_count_o = r_gen_count;
    assign stable_o    = r_stable;

    assign w_in_fire    = data_v_i & ready_o;
    assign w_out_fire   = yumi_i & data_v_o;
    assign w_gen_inc    = r_gen_count + gen_width_p'(1);
    assign w_still      = (w_board_next == r_board);
    assign w_frames_hit = (w_gen_inc == r_frames);

    // Neighbour indices are wrapped at elaboration; without wrap the
    // out-of-range neighbours are masked to dead instead.
    for (genvar gr = 0; gr < height_p; gr++) begin : g_row
        for (genvar gc = 0; gc < width_p; gc++) begin : g_col
            localparam int c_up = (gr == 0) ? height_p - 1 : gr - 1;
            localparam int c_dn = (gr == height_p - 1) ? 0 : gr + 1;
            localparam int c_lf = (gc == 0) ? width_p - 1 : gc - 1;
            localparam int c_rt = (gc == width_p - 1) ? 0 : gc + 1;
            localparam bit c_has_up = c_wrap || (gr > 0);
            localparam bit c_has_dn = c_wrap || (gr < height_p - 1);
            localparam bit c_has_lf = c_wrap || (gc > 0);
            localparam bit c_has_rt = c_wrap || (gc < width_p - 1);

            logic [7:0] w_nb;
            logic [3:0] w_n;

            assign w_nb[0] = c_has_up & c_has_lf & r_board[c_up][c_lf];
            assign w_nb[1] = c_has_up            & r_board[c_up][gc];
            assign w_nb[2] = c_has_up & c_has_rt & r_board[c_up][c_rt];
            assign w_nb[3] = c_has_lf            & r_board[gr][c_lf];
            assign w_nb[4] = c_has_rt            & r_board[gr][c_rt];
            assign w_nb[5] = c_has_dn & c_has_lf & r_board[c_dn][c_lf];
            assign w_nb[6] = c_has_dn            & r_board[c_dn][gc];
            assign w_nb[7] = c_has_dn & c_has_rt & r_board[c_dn][c_rt];

            assign w_n = 4'(w_nb[0]) + 4'(w_nb[1]) + 4'(w_nb[2]) + 4'(w_nb[3])
                       + 4'(w_nb[4]) + 4'(w_nb[5]) + 4'(w_nb[6]) + 4'(w_nb[7]);

            assign w_board_next[gr][gc] = (w_n == 4'd3) | ((w_n == 4'd2) & r_board[gr][gc]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_in_fire) w_state_next = LOAD;
            LOAD: if (w_in_fire && (r_wr_ptr == c_last_row))
                      w_state_next = (r_frames == '0) ? DONE : RUN;
            RUN:  if (w_still || w_frames_hit) w_state_next = DONE;
            DONE: if (w_out_fire && (r_rd_ptr == c_last_row)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_board     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_frames    <= '0;
            r_gen_count <= '0;
            r_stable    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (w_in_fire) begin
                    r_board[0]  <= data_i;
                    r_frames    <= frames_i;
                    r_gen_count <= '0;
                    r_stable    <= 1'b0;
                    r_wr_ptr    <= c_ptr_w'(1);
                end
                LOAD: if (w_in_fire) begin
                    r_board[r_wr_ptr] <= data_i;
                    r_wr_ptr          <= (r_wr_ptr == c_last_row) ? '0 : r_wr_ptr + c_ptr_w'(1);
                end
                RUN: begin
                    r_board     <= w_board_next;
                    r_gen_count <= w_gen_inc;
                    if (w_still) r_stable <= 1'b1;
                end
                DONE: if (w_out_fire) begin
                    r_rd_ptr <= (r_rd_ptr == c_last_row) ? '0 : r_rd_ptr + c_ptr_w'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bsg_cgol_board.sv
// ============================================================================
// Module   : tb_bsg_cgol_board
// Brief    : Self-checking bench for bsg_cgol_board with a reference Life
//            model feeding an expected-row scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsg_cgol_board;

    localparam int W = 8;
    localparam int H = 8;
    localparam int G = 16;

    typedef logic [H-1:0][W-1:0] board_t;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         data_v_i;
    logic [W-1:0] data_i;
    logic [G-1:0] frames_i;
    logic         ready_o;
    logic         data_v_o;
    logic [W-1:0] data_o;
    logic         yumi_i;
    logic [G-1:0] gen_count_o;
    logic         stable_o;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];

    bsg_cgol_board #(
        .width_p    (W),
        .height_p   (H),
        .gen_width_p(G)
    ) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .data_v_i   (data_v_i),
        .data_i     (data_i),
        .frames_i   (frames_i),
        .ready_o    (ready_o),
        .data_v_o   (data_v_o),
        .data_o     (data_o),
        .yumi_i     (yumi_i),
        .gen_count_o(gen_count_o),
        .stable_o   (stable_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic board_t model_step(board_t b);
        board_t nb;
        int n, rr, cc;
        nb = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef BSG_CGOL_BOARD_TORUS_EN
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                            n += int'(b[rr][cc]);
`else
                            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                                n += int'(b[rr][cc]);
`endif
                        end
                    end
                end
                nb[r][c] = (n == 3) || (n == 2 && b[r][c]);
            end
        end
        return nb;
    endfunction

    task automatic load_board(input board_t b, input logic [G-1:0] frames);
        for (int r = 0; r < H; r++) begin
            @(negedge clk_i);
            data_v_i = 1'b1;
            data_i   = b[r];
            frames_i = (r == 0) ? frames : G'($urandom);
        end
        @(negedge clk_i);
        data_v_i = 1'b0;
        data_i   = '0;
    endtask

    // Loads a board, predicts the outcome, waits for DONE and checks status.
    task automatic run_and_check(input string name, input board_t b, input logic [G-1:0] frames);
        board_t cur, nxt;
        int g, cnt;
        bit st;
        cur = b; g = 0; st = 1'b0;
        if (frames != '0) begin
            forever begin
                nxt = model_step(cur);
                g++;
                if (nxt == cur) st = 1'b1;
                cur = nxt;
                if (st || g == int'(frames)) break;
            end
        end
        for (int r = 0; r < H; r++) exp_q.push_back(cur[r]);

        load_board(b, frames);
        cnt = 0;
        while (data_v_o !== 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk_i);
        end
        tests++;
        if (cnt != g) begin
            fails++;
            $display("FAIL %s run_cycles: got %0d expected %0d", name, cnt, g);
        end
        tests++;
        if (gen_count_o !== G'(g)) begin
            fails++;
            $display("FAIL %s gen_count: got %0d expected %0d", name, gen_count_o, g);
        end
        tests++;
        if (stable_o !== st) begin
            fails++;
            $display("FAIL %s stable: got %0b expected %0b", name, stable_o, st);
        end
    endtask

    task automatic read_out(input string name, input int gap, input bit hold_in);
        logic [W-1:0] exp;
        if (hold_in) begin
            data_v_i = 1'b1;
            data_i   = '1;
        end
        for (int r = 0; r < H; r++) begin
            repeat (gap) @(negedge clk_i);
            exp = exp_q.pop_front();
            tests++;
            if (data_v_o !== 1'b1 || data_o !== exp) begin
                fails++;
                $display("FAIL %s row%0d: got v=%0b data=%h expected v=1 data=%h",
                         name, r, data_v_o, data_o, exp);
            end
            yumi_i = 1'b1;
            @(negedge clk_i);
            yumi_i = 1'b0;
        end
        data_v_i = 1'b0;
        data_i   = '0;
        tests++;
        if (ready_o !== 1'b1 || data_v_o !== 1'b0) begin
            fails++;
            $display("FAIL %s after_readout: got ready=%0b v=%0b expected ready=1 v=0",
                     name, ready_o, data_v_o);
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; data_v_i = 1'b0; data_i = '0; frames_i = '0; yumi_i = 1'b0;
        #1;
        tests++;
        if (ready_o !== 1'b1 || data_v_o !== 1'b0 || data_o !== '0 ||
            gen_count_o !== '0 || stable_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_in: got ready=%0b v=%0b data=%h gen=%0d st=%0b expected 1 0 00 0 0",
                     ready_o, data_v_o, data_o, gen_count_o, stable_o);
        end
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (ready_o !== 1'b1 || data_v_o !== 1'b0 || data_o !== '0) begin
            fails++;
            $display("FAIL reset_after: got ready=%0b v=%0b data=%h expected 1 0 00",
                     ready_o, data_v_o, data_o);
        end
    endtask

    task automatic test_blinker();
        board_t b = '0;
        b[2] = 8'h08; b[3] = 8'h08; b[4] = 8'h08;
        run_and_check("blinker1", b, 16'd1);
        read_out("blinker1", 0, 1'b0);
        run_and_check("blinker2", b, 16'd2);
        read_out("blinker2", 1, 1'b0);
    endtask

    task automatic test_block();
        board_t b = '0;
        b[3] = 8'h18; b[4] = 8'h18;
        run_and_check("block", b, 16'd100);
        read_out("block", 0, 1'b0);
    endtask

    task automatic test_edge();
        board_t b = '0;
        b[7] = 8'h08; b[0] = 8'h08; b[1] = 8'h08;
        run_and_check("edge", b, 16'd1);
        read_out("edge", 0, 1'b0);
    endtask

    task automatic test_handshake();
        board_t b;
        for (int r = 0; r < H; r++) b[r] = W'($urandom);
        run_and_check("frames0", b, 16'd0);
        read_out("frames0", 2, 1'b1);
    endtask

    task automatic test_random();
        board_t b;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < H; r++) b[r] = W'($urandom);
            run_and_check("random", b, G'($urandom_range(1, 12)));
            read_out("random", k, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        board_t b = '0;
        b[2] = 8'h08; b[3] = 8'h08; b[4] = 8'h08;
        load_board(b, 16'd1000);
        repeat (5) @(negedge clk_i);
        tests++;
        if (gen_count_o !== 16'd5 || data_v_o !== 1'b0 || ready_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_run: got gen=%0d v=%0b ready=%0b expected 5 0 0",
                     gen_count_o, data_v_o, ready_o);
        end
        #2 reset_n_i = 1'b0;
        #1;
        tests++;
        if (ready_o !== 1'b1 || data_v_o !== 1'b0 || gen_count_o !== '0 || stable_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_reset: got ready=%0b v=%0b gen=%0d st=%0b expected 1 0 0 0",
                     ready_o, data_v_o, gen_count_o, stable_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        run_and_check("zeros", '0, 16'd3);
        read_out("zeros", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block();
        test_edge();
        test_handshake();
        test_random();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
